// File: rtl/dds_wave_gen.sv
// dds_wave_gen
//   Direct digital synthesiser: phase accumulator, phase offset, truncation
//   and waveform synthesis (sine / square / triangle / sawtooth) into a signed
//   sample stream. Configuration is double-buffered: a load captures a shadow
//   set, which is applied either on the next cycle or at the next accumulator
//   wrap so a retune does not glitch the running waveform.
//
//   Optional feature macro: DDS_DITHER_EN
//     defined   : a 16-bit LFSR adds its low bits to the accumulator before the
//                 phase truncation (the accumulator itself is unaffected).
//     undefined : plain truncation.
//
//   The quarter-wave sine table is generated at elaboration from
//   ROM[i] = round(M*sin(2*pi*(i+0.5)/2^PHASE_W)). SINE_FILE names the matching
//   ROM image used by other flows; this RTL does not read it.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_en           advance accumulator and pipeline this cycle
//   i_cfg_load     strobe: capture i_cfg_* into the shadow registers
//   i_cfg_freq     frequency tuning word
//   i_cfg_phase    phase offset
//   i_cfg_mode     0 sine, 1 square, 2 triangle, 3 sawtooth
//   i_cfg_sync     1: apply shadow at the next wrap, 0: apply next cycle
//   i_cfg_clr      1: zero the accumulator when the shadow is applied
//   o_cfg_pending  shadow captured but not yet applied
//   o_wave_out     signed sample
//   o_wave_vld     o_wave_out holds a new sample
//   o_sync_out     marks the first sample after an accumulator wrap
module dds_wave_gen #(
  parameter int    ACC_W     = 32,
  parameter int    PHASE_W   = 12,
  parameter int    OUT_W     = 10,
  parameter string SINE_FILE = "sine_q.hex"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_cfg_load,
  input  logic [ACC_W-1:0]   i_cfg_freq,
  input  logic [PHASE_W-1:0] i_cfg_phase,
  input  logic [1:0]         i_cfg_mode,
  input  logic               i_cfg_sync,
  input  logic               i_cfg_clr,
  output logic               o_cfg_pending,
  output logic [OUT_W-1:0]   o_wave_out,
  output logic               o_wave_vld,
  output logic               o_sync_out
);

  localparam int ADDR_W = PHASE_W - 2;
  localparam int ROM_N  = 1 << ADDR_W;
  localparam int MAG_W  = OUT_W - 1;

  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_SQR  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SAW  = 2'd3;

  localparam logic [OUT_W-1:0] C_POS_FS = {1'b0, {MAG_W{1'b1}}};
  localparam logic [OUT_W-1:0] C_NEG_FS = {1'b1, {(MAG_W-1){1'b0}}, 1'b1};

  // pi in Q30
  localparam longint C_PI_Q30 = 64'sd3373259426;

  // Integer Taylor series so the table is a pure elaboration-time constant.
  function automatic logic [MAG_W-1:0] sine_mag(input int idx);
    longint x, x2, term, sum, mag;
    x    = (C_PI_Q30 * longint'(2 * idx + 1)) >>> PHASE_W;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    mag = (sum * longint'((1 << MAG_W) - 1) + (longint'(1) <<< 29)) >>> 30;
    return MAG_W'(mag);
  endfunction

  logic [MAG_W-1:0] w_rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    localparam logic [MAG_W-1:0] C_MAG = sine_mag(g);
    assign w_rom[g] = C_MAG;
  end

  logic [ACC_W-1:0]   r_acc, r_freq_act, r_sh_freq;
  logic [PHASE_W-1:0] r_phase_act, r_sh_phase;
  logic [1:0]         r_mode_act, r_sh_mode;
  logic               r_sh_sync, r_sh_clr, r_pending, r_wrap;

  logic [ACC_W:0]     w_sum;
  logic               w_carry, w_apply;
  logic [PHASE_W-1:0] w_acc_top;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_freq_act};
  assign w_carry = w_sum[ACC_W];
  // Wrap-synchronous apply needs a real wrap (en & carry); pending is only
  // visible from the cycle after the load, so the load's own wrap never counts.
  assign w_apply = r_pending & (~r_sh_sync | (i_en & w_carry));

`ifdef DDS_DITHER_EN
  localparam int DITH_W = (ACC_W - PHASE_W < 16) ? (ACC_W - PHASE_W) : 16;
  logic [15:0]      r_lfsr;
  logic             w_lfsr_fb;
  logic [ACC_W-1:0] w_dith_acc;
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_dith_acc = r_acc + ACC_W'(r_lfsr[DITH_W-1:0]);
  assign w_acc_top  = w_dith_acc[ACC_W-1 -: PHASE_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_lfsr <= 16'hACE1;
    else if (i_en) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end
`else
  assign w_acc_top = r_acc[ACC_W-1 -: PHASE_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_freq_act  <= '0;
      r_phase_act <= '0;
      r_mode_act  <= '0;
      r_sh_freq   <= '0;
      r_sh_phase  <= '0;
      r_sh_mode   <= '0;
      r_sh_sync   <= 1'b0;
      r_sh_clr    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_apply && r_sh_clr) r_acc <= '0;
      else if (i_en)           r_acc <= w_sum[ACC_W-1:0];
      // Held while disabled so the flag rides on the next emitted sample.
      if (i_en) r_wrap <= w_carry;
      if (w_apply) begin
        r_freq_act  <= r_sh_freq;
        r_phase_act <= r_sh_phase;
        r_mode_act  <= r_sh_mode;
      end
      if (i_cfg_load) begin
        r_sh_freq  <= i_cfg_freq;
        r_sh_phase <= i_cfg_phase;
        r_sh_mode  <= i_cfg_mode;
        r_sh_sync  <= i_cfg_sync;
        r_sh_clr   <= i_cfg_clr;
      end
      r_pending <= i_cfg_load | (r_pending & ~w_apply);
    end
  end

  logic [PHASE_W-1:0] r_p1;
  logic [1:0]         r_mode1;
  logic               r_v1, r_v2, r_vld, r_sync1, r_sync2, r_sync3;
  logic [OUT_W-1:0]   r_wave2, r_wave3;

  logic               w_msb, w_tri_top;
  logic [ADDR_W-1:0]  w_addr;
  logic [MAG_W-1:0]   w_mag, w_tri_body;
  logic [OUT_W-1:0]   w_sine_pos, w_wave;

  always_comb begin
    w_msb      = r_p1[PHASE_W-1];
    w_addr     = r_p1[PHASE_W-2] ? ~r_p1[PHASE_W-3:0] : r_p1[PHASE_W-3:0];
    w_mag      = w_rom[w_addr];
    w_sine_pos = {1'b0, w_mag};
    // Triangle folds the second half by inverting the lower phase bits.
    w_tri_top  = w_msb ^ r_p1[PHASE_W-2];
    w_tri_body = r_p1[PHASE_W-3 -: MAG_W] ^ {MAG_W{w_msb}};
    w_wave     = '0;
    case (r_mode1)
      MODE_SINE: w_wave = w_msb ? -w_sine_pos : w_sine_pos;
      MODE_SQR:  w_wave = w_msb ? C_NEG_FS : C_POS_FS;
      MODE_TRI:  w_wave = {~w_tri_top, w_tri_body};
      MODE_SAW:  w_wave = {~w_msb, r_p1[PHASE_W-2 -: MAG_W]};
      default:   w_wave = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1    <= '0;
      r_mode1 <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_wave2 <= '0;
      r_wave3 <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_v1  <= i_en;
      r_v2  <= r_v1;
      r_vld <= r_v2;
      // Stage 1 samples the accumulator value that is current while en is high.
      if (i_en) begin
        r_p1    <= w_acc_top + r_phase_act;
        r_mode1 <= r_mode_act;
        r_sync1 <= r_wrap;
      end
      if (r_v1) begin
        r_wave2 <= w_wave;
        r_sync2 <= r_sync1;
      end
      if (r_v2) r_wave3 <= r_wave2;
      r_sync3 <= r_v2 & r_sync2;
    end
  end

  assign o_cfg_pending = r_pending;
  assign o_wave_out    = r_wave3;
  assign o_wave_vld    = r_vld;
  assign o_sync_out    = r_sync3;

endmodule
